source_dispense_seq: RTL and testbench
======================================

SOURCE_DISPENSE_SEQ -- requirements
Module: source_dispense_seq

Interface
REQ-001 Parameter VOL_W, default 8: width of dispense volume, in pump steps.
REQ-002 Parameter STEP_DIV, default 16: clock cycles per pump step (>=2).
REQ-003 Parameter VALVE_LEAD, default 4: cycles the inlet valve is open before pumping starts (>=1).
REQ-004 Parameter SETTLE_CYC, default 32: cycles of settle time after the valve closes (>=1).
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 req_valid  in  1  host dispense request.
REQ-008 req_vol  in  VOL_W  requested steps; sampled at handshake.
REQ-009 req_ready  out  1  high only in IDLE.
REQ-010 abort  in  1  level; terminates the current dispense.
REQ-011 valve_open  out  1  inlet valve drive into the chip Source port.
REQ-012 pump_step  out  1  one-cycle syringe-pump step pulse.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 aborted  out  1  one-cycle pulse, coincident with done, when the run was aborted.
REQ-016 steps_done  out  VOL_W  pump steps issued in the current or last run.

Function
REQ-017 The FSM SHALL have states IDLE, LEAD, PUMP, SETTLE and FIN.
REQ-018 A handshake occurs on an edge where req_valid and req_ready are both high (cycle T0). At T0 the block latches req_vol, clears steps_done and moves to LEAD.
REQ-019 The block SHALL stay in LEAD for VALVE_LEAD cycles, then move to PUMP.
REQ-020 In PUMP, pump_step SHALL pulse on the last cycle of each STEP_DIV-cycle window and steps_done SHALL increment on the same edge.
REQ-021 After the pulse that makes steps_done equal the latched volume, the block SHALL move to SETTLE.
REQ-022 valve_open SHALL be high exactly in LEAD and PUMP and registered, with no glitches.
REQ-023 The block SHALL stay in SETTLE for SETTLE_CYC cycles, then move to FIN.
REQ-024 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-025 Total latency SHALL be: done high in cycle T0 + VALVE_LEAD + vol*STEP_DIV + SETTLE_CYC + 1.
REQ-026 Zero volume: the block SHALL go from LEAD directly to SETTLE, issue no pump_step, and keep valve_open high for VALVE_LEAD cycles only.
REQ-027 Maximum volume (all ones) SHALL complete with no wrap-around of steps_done or the step counter.
REQ-028 abort high in LEAD or PUMP: next state is SETTLE, valve closes and no further pump_step is issued. A pulse scheduled on the same cycle is suppressed.
REQ-029 On an aborted run, the aborted flag SHALL be held and asserted with done in FIN.
REQ-030 abort in SETTLE, FIN or IDLE SHALL be ignored.
REQ-031 req_valid while busy SHALL be ignored (no queuing). A request held through FIN SHALL be accepted on the first IDLE cycle.
REQ-032 steps_done SHALL hold its value after FIN until the next handshake.

Reset
REQ-033 rst SHALL force, asynchronously: IDLE, req_ready=1, valve_open=0, pump_step=0, busy=0, done=0, aborted=0, steps_done=0, and clear all counters.
REQ-034 Reset during any state SHALL close the valve immediately. No done pulse is issued for the interrupted run.
REQ-035 The first handshake is allowed on the first rising edge after rst deasserts.

Structure
REQ-036 Package src_disp_pkg SHALL hold the state enum and the default values of STEP_DIV, VALVE_LEAD and SETTLE_CYC.
REQ-037 Sub-module step_timer (a programmable prescaler emitting a terminal-count tick, with a sync clear) SHALL generate the pump_step cadence. It is cleared on entry to PUMP.
REQ-038 All outputs SHALL be driven directly from flops.

Verification (defaults)
REQ-039 Nominal: vol=3 accepted at T0 -> valve_open high T0+1..T0+52; pump_step at T0+20, T0+36, T0+52; done at T0+85; steps_done=3.
REQ-040 Zero volume: vol=0 -> valve_open high 4 cycles, no pump_step, done at T0+37.
REQ-041 Abort: vol=10, abort at T0+30 -> exactly 1 pump_step, valve low from T0+31, done and aborted together at T0+63, steps_done=1.
REQ-042 Busy request: req_valid held high from T0 -> second handshake one cycle after done. Requests while busy produce no effect.
REQ-043 Reset mid-PUMP: rst asserted mid-PUMP -> valve_open=0 immediately, no done pulse, req_ready=1 after release.
REQ-044 Maximum volume: vol=255 -> 255 pulses, steps_done=255, done at T0+4080+37.

Source files
------------

// File: rtl/src_disp_pkg.sv
// ============================================================================
// Module      : src_disp_pkg
// Description : Shared state encoding and default timing for the source
//               dispense sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package src_disp_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEAD   = 3'd1,
        PUMP   = 3'd2,
        SETTLE = 3'd3,
        FIN    = 3'd4
    } state_t;

    localparam int VOL_W_DEF      = 8;
    localparam int STEP_DIV_DEF   = 16;
    localparam int VALVE_LEAD_DEF = 4;
    localparam int SETTLE_CYC_DEF = 32;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/source_dispense_seq_step_timer.sv
// ============================================================================
// Module      : step_timer
// Description : Programmable prescaler with a one-cycle-early terminal-count
//               tick, so the caller can register the tick onto the TC cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] period_m1,
    output logic         tick_ahead
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == period_m1) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High in the cycle before the count reaches period_m1.
    assign tick_ahead = en && (cnt_q == (period_m1 - W'(1)));

endmodule

`default_nettype wire

// File: rtl/source_dispense_seq.sv
// ============================================================================
// Module      : source_dispense_seq
// Description : Valve-lead / pump / settle dispense sequencer driving the
//               chip Source inlet valve and a syringe-pump step line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module source_dispense_seq
    import src_disp_pkg::*;
#(
    parameter int VOL_W      = VOL_W_DEF,
    parameter int STEP_DIV   = STEP_DIV_DEF,
    parameter int VALVE_LEAD = VALVE_LEAD_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [VOL_W-1:0] req_vol,
    output logic             req_ready,
    input  logic             abort,
    output logic             valve_open,
    output logic             pump_step,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [VOL_W-1:0] steps_done
);

    localparam int CW = $clog2(max_int(VALVE_LEAD, SETTLE_CYC) + 1);
    localparam int TW = $clog2(STEP_DIV);

    localparam logic [CW-1:0]  C_LEAD_LAST   = CW'(VALVE_LEAD - 1);
    localparam logic [CW-1:0]  C_SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0]  C_STEP_LAST   = TW'(STEP_DIV - 1);
    localparam logic [VOL_W:0] C_ONE         = 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [VOL_W-1:0] vol_q, vol_d;
    logic [VOL_W-1:0] steps_done_q, steps_done_d;
    logic             abort_seen_q, abort_seen_d;
    logic             req_ready_q, req_ready_d;
    logic             valve_open_q, valve_open_d;
    logic             pump_step_q, pump_step_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic             timer_clr;
    logic             timer_en;
    logic             tick_ahead;
    logic [VOL_W:0]   steps_inc;

    step_timer #(
        .W (TW)
    ) u_step_timer (
        .clk        (clk),
        .rst        (rst),
        .clr        (timer_clr),
        .en         (timer_en),
        .period_m1  (C_STEP_LAST),
        .tick_ahead (tick_ahead)
    );

    // One bit wider than the volume so the last-step compare cannot wrap.
    assign steps_inc = {1'b0, steps_done_q} + C_ONE;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CW'(1);
        vol_d        = vol_q;
        steps_done_d = steps_done_q;
        abort_seen_d = abort_seen_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid && req_ready_q) begin
                    state_d      = LEAD;
                    vol_d        = req_vol;
                    steps_done_d = '0;
                    abort_seen_d = 1'b0;
                end
            end
            LEAD: begin
                if (abort) begin
                    state_d      = SETTLE;
                    abort_seen_d = 1'b1;
                    cnt_d        = '0;
                end else if (cnt_q == C_LEAD_LAST) begin
                    state_d = (vol_q == '0) ? SETTLE : PUMP;
                    cnt_d   = '0;
                end
            end
            PUMP: begin
                cnt_d = '0;
                // A pulse already on the wire is counted even if abort arrives with it.
                if (pump_step_q) begin
                    steps_done_d = steps_inc[VOL_W-1:0];
                end
                if (abort) begin
                    state_d      = SETTLE;
                    abort_seen_d = 1'b1;
                end else if (pump_step_q && (steps_inc == {1'b0, vol_q})) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == C_SETTLE_LAST) begin
                    state_d = FIN;
                    cnt_d   = '0;
                end
            end
            FIN: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        timer_clr = (state_d == PUMP) && (state_q != PUMP);
        timer_en  = (state_q == PUMP);

        // Outputs are registered from the next state so they align with it.
        pump_step_d  = (state_q == PUMP) && (state_d == PUMP) && tick_ahead && !abort;
        valve_open_d = (state_d == LEAD) || (state_d == PUMP);
        busy_d       = (state_d != IDLE);
        req_ready_d  = (state_d == IDLE);
        done_d       = (state_d == FIN);
        aborted_d    = (state_d == FIN) && abort_seen_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            vol_q        <= '0;
            steps_done_q <= '0;
            abort_seen_q <= 1'b0;
            req_ready_q  <= 1'b1;
            valve_open_q <= 1'b0;
            pump_step_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vol_q        <= vol_d;
            steps_done_q <= steps_done_d;
            abort_seen_q <= abort_seen_d;
            req_ready_q  <= req_ready_d;
            valve_open_q <= valve_open_d;
            pump_step_q  <= pump_step_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign valve_open = valve_open_q;
    assign pump_step  = pump_step_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign steps_done = steps_done_q;

endmodule

`default_nettype wire

// File: tb/tb_source_dispense_seq.sv
// ============================================================================
// Module      : tb_source_dispense_seq
// Description : Directed self-checking bench for source_dispense_seq at
//               default parameters; cycle k is counted from handshake T0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_source_dispense_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [7:0] req_vol;
    logic       req_ready;
    logic       abort;
    logic       valve_open;
    logic       pump_step;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [7:0] steps_done;

    int tests = 0;
    int fails = 0;

    int n_pulse, p1, p2, p3, v_first, v_last, n_valve;
    int done_k, ab_done, sd_done, extra_ab, done_seen;

    source_dispense_seq dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_vol    (req_vol),
        .req_ready  (req_ready),
        .abort      (abort),
        .valve_open (valve_open),
        .pump_step  (pump_step),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .steps_done (steps_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Must be entered at the falling edge of an IDLE cycle (cycle T0).
    task automatic run(input int vol, input int abort_at, input bit hold, input int limit);
        n_pulse = 0; p1 = -1; p2 = -1; p3 = -1;
        v_first = -1; v_last = -1; n_valve = 0;
        done_k = -1; ab_done = -1; sd_done = -1; extra_ab = 0;
        req_vol   = 8'(vol);
        req_valid = 1'b1;
        for (int k = 1; k <= limit && done_k < 0; k++) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            if (valve_open) begin
                if (v_first < 0) v_first = k;
                v_last = k;
                n_valve++;
            end
            if (pump_step) begin
                n_pulse++;
                if (n_pulse == 1) p1 = k;
                else if (n_pulse == 2) p2 = k;
                else if (n_pulse == 3) p3 = k;
            end
            if (aborted && !done) extra_ab++;
            if (done) begin
                done_k  = k;
                ab_done = int'(aborted);
                sd_done = int'(steps_done);
            end
            abort = (k == abort_at);
        end
        abort = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_vol   = '0;
        abort     = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_req_ready",  int'(req_ready),  1);
        chk("rst_busy",       int'(busy),       0);
        chk("rst_valve",      int'(valve_open), 0);
        chk("rst_pump",       int'(pump_step),  0);
        chk("rst_done",       int'(done),       0);
        chk("rst_aborted",    int'(aborted),    0);
        chk("rst_steps_done", int'(steps_done), 0);

        // First handshake on the very first edge after release.
        rst = 1'b0;
        run(3, 0, 1'b0, 200);
        chk("nom_valve_first", v_first, 1);
        chk("nom_valve_last",  v_last,  52);
        chk("nom_valve_cnt",   n_valve, 52);
        chk("nom_pulses",      n_pulse, 3);
        chk("nom_p1",          p1,      20);
        chk("nom_p2",          p2,      36);
        chk("nom_p3",          p3,      52);
        chk("nom_done_cycle",  done_k,  85);
        chk("nom_aborted",     ab_done, 0);
        chk("nom_steps",       sd_done, 3);
        @(negedge clk);
        chk("nom_steps_hold",  int'(steps_done), 3);
        chk("nom_ready_after", int'(req_ready),  1);

        run(0, 0, 1'b0, 200);
        chk("zero_valve_first", v_first, 1);
        chk("zero_valve_last",  v_last,  4);
        chk("zero_pulses",      n_pulse, 0);
        chk("zero_done_cycle",  done_k,  37);
        chk("zero_steps",       sd_done, 0);
        @(negedge clk);

        run(10, 30, 1'b0, 200);
        chk("abt_pulses",     n_pulse,  1);
        chk("abt_p1",         p1,       20);
        chk("abt_valve_last", v_last,   30);
        chk("abt_done_cycle", done_k,   63);
        chk("abt_aborted",    ab_done,  1);
        chk("abt_early_flag", extra_ab, 0);
        chk("abt_steps",      sd_done,  1);
        @(negedge clk);

        run(5, 2, 1'b0, 200);
        chk("abtlead_valve_last", v_last,  2);
        chk("abtlead_pulses",     n_pulse, 0);
        chk("abtlead_done_cycle", done_k,  35);
        chk("abtlead_aborted",    ab_done, 1);
        @(negedge clk);

        // Abort on the edge that would register a pulse suppresses it.
        run(4, 19, 1'b0, 200);
        chk("abtsup_pulses",     n_pulse, 0);
        chk("abtsup_valve_last", v_last,  19);
        chk("abtsup_done_cycle", done_k,  52);
        chk("abtsup_steps",      sd_done, 0);
        chk("abtsup_aborted",    ab_done, 1);
        @(negedge clk);

        run(1, 30, 1'b0, 200);
        chk("abtsettle_done_cycle", done_k,  53);
        chk("abtsettle_aborted",    ab_done, 0);
        chk("abtsettle_steps",      sd_done, 1);
        @(negedge clk);

        // Abort asserted across the handshake edge while still IDLE.
        abort = 1'b1;
        run(2, 0, 1'b0, 200);
        chk("abtidle_done_cycle", done_k,  69);
        chk("abtidle_aborted",    ab_done, 0);
        chk("abtidle_pulses",     n_pulse, 2);
        @(negedge clk);

        // Request held high throughout: ignored while busy, re-accepted after FIN.
        run(1, 0, 1'b1, 200);
        chk("hold_done_cycle", done_k,  53);
        chk("hold_pulses",     n_pulse, 1);
        @(negedge clk);
        chk("hold_idle_ready", int'(req_ready), 1);
        chk("hold_idle_busy",  int'(busy),      0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("hold_second_busy",  int'(busy),       1);
        chk("hold_second_steps", int'(steps_done), 0);

        repeat (9) @(negedge clk);
        chk("rstmid_valve_before", int'(valve_open), 1);
        rst = 1'b1;
        #1;
        chk("rstmid_valve",     int'(valve_open), 0);
        chk("rstmid_busy",      int'(busy),       0);
        chk("rstmid_req_ready", int'(req_ready),  1);
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("rstmid_no_done", done_seen, 0);
        rst = 1'b0;
        chk("rstmid_ready_after", int'(req_ready), 1);

        run(255, 0, 1'b0, 5000);
        chk("max_pulses",     n_pulse, 255);
        chk("max_steps",      sd_done, 255);
        chk("max_done_cycle", done_k,  4117);
        chk("max_valve_last", v_last,  4084);
        chk("max_aborted",    ab_done, 0);
        @(negedge clk);
        chk("max_steps_hold", int'(steps_done), 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
